// File: rtl/hex_disp_if.sv
// Bundles the load/value/control inputs and segment/phase outputs of the hex display driver.
interface hex_disp_if #(
  parameter int NUM_DIGITS = 6
);
  logic                    load;
  logic [4*NUM_DIGITS-1:0] value;
  logic                    lz_blank;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic [NUM_DIGITS-1:0]   blink_mask;
  logic [7*NUM_DIGITS-1:0] segments;
  logic                    blink_phase;

  modport master (
    output load, value, lz_blank, digit_en, blink_mask,
    input  segments, blink_phase
  );

  modport slave (
    input  load, value, lz_blank, digit_en, blink_mask,
    output segments, blink_phase
  );
endinterface

// File: rtl/hex_display_driver.sv
// Registered multi-digit hex 7-segment driver (active-low gfedcba) with per-digit
// enable, leading-zero blanking and a divider-timed blink mask.
module hex_digit_lane (
  input  logic [3:0] nibble_i,
  input  logic       en_i,
  input  logic       blink_i,
  input  logic       phase_i,
  input  logic       lz_i,
  output logic [6:0] seg_o
);
  logic [6:0] enc;

  always_comb begin
    enc = 7'h7F;
    unique case (nibble_i)
      4'h0: enc = 7'h40;  4'h1: enc = 7'h79;  4'h2: enc = 7'h24;  4'h3: enc = 7'h30;
      4'h4: enc = 7'h19;  4'h5: enc = 7'h12;  4'h6: enc = 7'h02;  4'h7: enc = 7'h78;
      4'h8: enc = 7'h00;  4'h9: enc = 7'h18;  4'hA: enc = 7'h08;  4'hB: enc = 7'h03;
      4'hC: enc = 7'h46;  4'hD: enc = 7'h21;  4'hE: enc = 7'h06;  4'hF: enc = 7'h0E;
      default: enc = 7'h7F;
    endcase
  end

  // Disable beats blink-off, which beats leading-zero blanking.
  always_comb begin
    seg_o = enc;
    if (!en_i)                 seg_o = 7'h7F;
    else if (blink_i && !phase_i) seg_o = 7'h7F;
    else if (lz_i)             seg_o = 7'h7F;
  end
endmodule

module hex_display_driver #(
  parameter int NUM_DIGITS = 6,
  parameter int BLINK_DIV  = 25000000
) (
  input  logic       clock,
  input  logic       resetn,
  hex_disp_if.slave  bus
);
  localparam int             CW       = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(BLINK_DIV - 1);

  logic [NUM_DIGITS-1:0][3:0] held_q, held_d;
  logic [NUM_DIGITS-1:0][6:0] seg_q, seg_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic                       phase_q, phase_d;
  logic                       wrap;

  assign held_d  = bus.load ? bus.value : held_q;
  assign wrap    = (cnt_q == CNT_LAST);
  assign cnt_d   = wrap ? '0 : cnt_q + 1'b1;
  assign phase_d = phase_q ^ wrap;

  genvar i;
  generate
    for (i = 0; i < NUM_DIGITS; i++) begin : g_lane
      logic lz;
      if (i == 0) begin : g_lsd
        assign lz = 1'b0;
      end else begin : g_upper
        // Digit i is a leading zero when it and every more significant digit are zero.
        logic upper_zero;
        if (i == NUM_DIGITS - 1) begin : g_top
          assign upper_zero = (held_q[i] == 4'h0);
        end else begin : g_mid
          assign upper_zero = (held_q[i] == 4'h0) && g_lane[i+1].g_upper.upper_zero;
        end
        assign lz = bus.lz_blank && upper_zero;
      end

      hex_digit_lane u_lane (
        .nibble_i (held_q[i]),
        .en_i     (bus.digit_en[i]),
        .blink_i  (bus.blink_mask[i]),
        .phase_i  (phase_q),
        .lz_i     (lz),
        .seg_o    (seg_d[i])
      );
    end
  endgenerate

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      held_q  <= '0;
      seg_q   <= '1;
      cnt_q   <= '0;
      phase_q <= 1'b1;
    end else begin
      held_q  <= held_d;
      seg_q   <= seg_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign bus.segments    = seg_q;
  assign bus.blink_phase = phase_q;
endmodule

// File: doc/hex_display_driver.md
Name: hex_display_driver

Overview:
Registered multi-digit hexadecimal 7-segment display driver and the parametrised successor to the single-digit combinational decoder. It captures a NUM_DIGITS-nibble value on a load strobe and drives NUM_DIGITS active-low segment outputs in parallel. Per-digit enable, optional leading-zero blanking and a per-digit blink mask are applied, with blink timing generated by an internal divider. It sits between the cellular-automaton control/stat logic (generation counter, population count) and the board HEX displays.

Parameters:
NUM_DIGITS, 6, number of hex digits driven (1..8)
BLINK_DIV, 25000000, clock cycles per blink half-period (>=2)

Ports:
clock  input  1  system clock, all logic on rising edge
resetn  input  1  asynchronous active-low reset
load  input  1  capture value into the held register this cycle
value  input  4*NUM_DIGITS  digit i = value[4i+3:4i], digit 0 least significant
lz_blank  input  1  1 = blank leading zeros
digit_en  input  NUM_DIGITS  per-digit display enable
blink_mask  input  NUM_DIGITS  1 = digit blinks
segments  output  7*NUM_DIGITS  digit i = segments[7i+6:7i], bit order gfedcba, active-low, registered
blink_phase  output  1  1 = blink "on" half-period, registered

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (resetn). All state is cleared immediately on resetn=0, independent of clock.
- Reset values: held register = 0; segments = all 7'h7F (all blank); blink counter = 0; blink_phase = 1.
- Held register: on a rising edge with load=1, held <= value. With load=0 it holds. No handshake; load is accepted every cycle.
- Segment register: updated every rising edge from current held, lz_blank, digit_en, blink_mask and blink_phase. Latency from load to segments is 2 edges: value sampled at edge N, visible on segments after edge N+1. Control-input changes are visible 1 edge later.
- Encoding (hex of gfedcba, active-low):
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:18, A:08, B:03, C:46, D:21, E:06, F:0E
  - blank: 7F
- Per-digit blanking precedence, evaluated for each digit i:
  - digit_en[i]=0 -> blank;
  - else blink_mask[i]=1 and blink_phase=0 -> blank;
  - else lz_blank=1 and digit i is a leading zero -> blank;
  - else the encoded nibble.
- Leading zero: digit i (i>=1) is a leading zero when held nibbles i..NUM_DIGITS-1 are all 0. Digit 0 is never a leading zero, so value 0 with lz_blank shows a single "0". digit_en and blink do not alter leading-zero detection.
- Blink divider: counter runs 0..BLINK_DIV-1 every cycle. At BLINK_DIV-1 it wraps to 0 and blink_phase toggles on the same edge. Full period = 2*BLINK_DIV cycles. load and the masks do not affect the counter.
- Simultaneous events:
  - load and a blink toggle on the same edge: both take effect; the following segment update uses the new held value and the new phase.
  - resetn asserted mid-operation: outputs blank immediately; blink restarts in the "on" phase.
- Counter width: clog2(BLINK_DIV). No other arithmetic.

Test Plan:
- Reset behaviour: NUM_DIGITS=6, drive resetn=0 asynchronously mid-cycle -> segments=42'h3FF_FFFF_FFFF and blink_phase=1 immediately. After release with digit_en=6'h3F, lz_blank=0, second edge -> every digit 40.
- Load latency and encoding: load=1 with value=24'h0123AF at edge N -> segments unchanged after edge N. After edge N+1, digits 5..0 = 40,79,24,30,08,0E.
- Leading-zero blanking: held=24'h0000A0, lz_blank=1 -> digits 5..2 = 7F, digit 1 = 08, digit 0 = 40. Held=0 -> only digit 0 = 40. Held=24'h100000 -> no blanking.
- Blink timing: BLINK_DIV=4, blink_mask=6'b000001, held=5 -> blink_phase toggles every 4 cycles. Digit 0 alternates 12/7F, lagging the phase by 1 edge; other digits stay steady.
- Precedence: digit_en[3]=0 with blink on and a nonzero digit 3 -> digit 3 = 7F regardless of phase. Re-enable -> digit 3 shows its encoding after 1 edge.
- Load during a blink toggle: BLINK_DIV=4, load value 24'hFFFFFF on the wrap edge -> next edge shows 0E on unmasked digits and the new phase on masked digits.
